// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifu_fetch_pkg;

   localparam logic [31:0] NOP              = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        misalign;
   } fetch_entry_t;

   function automatic fetch_entry_t empty_entry();
      return '{inst: NOP, pc: 32'h0, misalign: 1'b0};
   endfunction

endpackage

// File: rtl/ifu_fetch_buf.sv
// Two-entry fetch output FIFO with flush; the head shows a NOP at pc 0 when empty.
// A flush in the same cycle as an enqueue leaves exactly that new entry.
module ifu_fetch_buf
   import ifu_fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         enq,
   input  fetch_entry_t enq_entry,
   input  logic         deq,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   fetch_entry_t mem [2];
   logic         rd_ptr;
   logic         wr_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else if (flush) begin
         count  <= {1'b0, enq};
         rd_ptr <= 1'b0;
         wr_ptr <= enq;
      end else begin
         if (enq) wr_ptr <= ~wr_ptr;
         if (deq) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, enq} - {1'b0, deq};
      end
   end

   always_ff @(posedge clk) begin
      if (enq) mem[flush ? 1'b0 : wr_ptr] <= enq_entry;
   end

   assign head = (count != 2'd0) ? mem[rd_ptr] : empty_entry();

endmodule

// File: rtl/ifu_fetch.sv
// Fetch front end: PC generation, ROM addressing, credit-limited issue and redirect flush.
// Optional IFU_ALIGN_CHK_EN turns misaligned redirect targets into a single flagged NOP and halts fetch.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W   = 9,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned DEPTH    = 2
)(
   input  logic              clka,
   input  logic              rsta,
   output logic [ADDR_W-1:0] addra,
   input  logic [31:0]       douta,
   output logic [31:0]       inst_o,
   output logic [31:0]       inst_pc_o,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
`ifdef IFU_ALIGN_CHK_EN
   output logic              inst_misalign_o,
`endif
   input  logic              redirect_valid_i,
   input  logic [31:0]       redirect_pc_i
);

   logic [31:0]  pc_q;
   logic [31:0]  req_pc_q;
   logic         req_q;
   logic         halt_q;
   logic [1:0]   count;
   logic [2:0]   occ;
   logic         deq;
   logic         issue;
   logic         redirect;
   logic         misalign_redirect;
   logic [31:0]  target;
   logic         enq;
   fetch_entry_t enq_entry;
   fetch_entry_t head;

   assign redirect = redirect_valid_i & ~rsta;

`ifdef IFU_ALIGN_CHK_EN
   assign target            = redirect_pc_i;
   assign misalign_redirect = redirect & (redirect_pc_i[1:0] != 2'b00);
`else
   assign target            = redirect_pc_i & ~32'h3;
   assign misalign_redirect = 1'b0;
`endif

   assign inst_valid_o = (count != 2'd0);
   assign deq          = inst_valid_o & inst_ready_i;
   // Buffered plus in-flight entries after this cycle's dequeue must leave room for one more read.
   assign occ          = {1'b0, count} + {2'b0, req_q} - {2'b0, deq};
   assign issue        = (occ < 3'(DEPTH)) & ~halt_q;

   always_comb begin
      enq       = req_q & ~redirect;
      enq_entry = '{inst: douta, pc: req_pc_q, misalign: 1'b0};
      if (misalign_redirect) begin
         enq       = 1'b1;
         enq_entry = '{inst: NOP, pc: redirect_pc_i, misalign: 1'b1};
      end
   end

   always_comb begin
      if (rsta)          addra = RESET_PC[ADDR_W+1:2];
      else if (redirect) addra = target[ADDR_W+1:2];
      else               addra = pc_q[ADDR_W+1:2];
   end

   always_ff @(posedge clka) begin
      if (rsta) begin
         pc_q     <= RESET_PC;
         req_pc_q <= 32'h0;
         req_q    <= 1'b0;
         halt_q   <= 1'b0;
      end else if (redirect) begin
         if (misalign_redirect) begin
            req_q  <= 1'b0;
            halt_q <= 1'b1;
            pc_q   <= target;
         end else begin
            req_q    <= 1'b1;
            halt_q   <= 1'b0;
            req_pc_q <= target;
            pc_q     <= target + 32'd4;
         end
      end else if (issue) begin
         req_q    <= 1'b1;
         req_pc_q <= pc_q;
         pc_q     <= pc_q + 32'd4;
      end else begin
         req_q <= 1'b0;
      end
   end

   ifu_fetch_buf u_buf (
      .clk       (clka),
      .rst       (rsta),
      .flush     (redirect),
      .enq       (enq),
      .enq_entry (enq_entry),
      .deq       (deq),
      .head      (head),
      .count     (count)
   );

   assign inst_o    = head.inst;
   assign inst_pc_o = head.pc;

`ifdef IFU_ALIGN_CHK_EN
   assign inst_misalign_o = head.misalign;
`else
   logic unused_misalign;
   assign unused_misalign = head.misalign;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: ROM model returns word k = k, table of per-cycle vectors plus corner sequences.
module tb_ifu_fetch;

   logic        clka = 1'b0;
   logic        rsta;
   logic [8:0]  addra;
   logic [31:0] douta = 32'h0;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
`ifdef IFU_ALIGN_CHK_EN
   logic        inst_misalign_o;
`endif

   int passed = 0;
   int total  = 0;

   always #5 clka = ~clka;

   always @(posedge clka) douta <= {23'b0, addra};

   ifu_fetch dut (
      .clka             (clka),
      .rsta             (rsta),
      .addra            (addra),
      .douta            (douta),
      .inst_o           (inst_o),
      .inst_pc_o        (inst_pc_o),
      .inst_valid_o     (inst_valid_o),
      .inst_ready_i     (inst_ready_i),
`ifdef IFU_ALIGN_CHK_EN
      .inst_misalign_o  (inst_misalign_o),
`endif
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i)
   );

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        redir;
      logic [31:0] rpc;
      logic        vld;
      logic [31:0] inst;
      logic [31:0] pc;
      logic [8:0]  addr;
   } vec_t;

   localparam int NV = 35;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic rst, input logic rdy, input logic redir,
                               input logic [31:0] rpc, input logic vld,
                               input logic [31:0] inst, input logic [31:0] pc,
                               input logic [8:0] addr);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
      v.vld = vld; v.inst = inst; v.pc = pc; v.addr = addr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic drive(input logic rst, input logic rdy, input logic redir, input logic [31:0] rpc);
      rsta             = rst;
      inst_ready_i     = rdy;
      redirect_valid_i = redir;
      redirect_pc_i    = rpc;
      #1;
   endtask

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   task automatic chk_head(input string name, input logic vld, input logic [31:0] inst,
                           input logic [31:0] pc);
      chk({name, "_valid"}, 32'(inst_valid_o), 32'(vld));
      chk({name, "_inst"}, inst_o, inst);
      chk({name, "_pc"}, inst_pc_o, pc);
   endtask

   initial begin
      rsta             = 1'b1;
      inst_ready_i     = 1'b0;
      redirect_valid_i = 1'b0;
      redirect_pc_i    = 32'h0;

      // reset, startup latency, streaming
      tbl[0]  = mk(1, 1, 0, 0, 0, 32'h13, 0, 0);
      tbl[1]  = mk(0, 1, 0, 0, 0, 32'h13, 0, 0);
      tbl[2]  = mk(0, 1, 0, 0, 0, 32'h13, 0, 1);
      tbl[3]  = mk(0, 1, 0, 0, 1, 0, 0, 2);
      tbl[4]  = mk(0, 1, 0, 0, 1, 1, 4, 3);
      tbl[5]  = mk(0, 1, 0, 0, 1, 2, 8, 4);
      tbl[6]  = mk(0, 1, 0, 0, 1, 3, 12, 5);
      // reset mid-stream, then 10 cycles of backpressure
      tbl[7]  = mk(1, 1, 0, 0, 1, 4, 16, 0);
      tbl[8]  = mk(0, 1, 0, 0, 0, 32'h13, 0, 0);
      tbl[9]  = mk(0, 0, 0, 0, 0, 32'h13, 0, 1);
      for (int i = 10; i <= 18; i++) tbl[i] = mk(0, 0, 0, 0, 1, 0, 0, 2);
      tbl[19] = mk(0, 1, 0, 0, 1, 0, 0, 2);
      tbl[20] = mk(0, 1, 0, 0, 1, 1, 4, 3);
      tbl[21] = mk(0, 1, 0, 0, 1, 2, 8, 4);
      // redirect with a buffered head and a read in flight
      tbl[22] = mk(0, 0, 1, 32'h100, 1, 3, 12, 64);
      tbl[23] = mk(0, 1, 0, 0, 0, 32'h13, 0, 65);
      tbl[24] = mk(0, 1, 0, 0, 1, 64, 32'h100, 66);
      // back-to-back redirects
      tbl[25] = mk(0, 1, 1, 32'h40, 1, 65, 32'h104, 16);
      tbl[26] = mk(0, 1, 1, 32'h80, 0, 32'h13, 0, 32);
      tbl[27] = mk(0, 1, 0, 0, 0, 32'h13, 0, 33);
      tbl[28] = mk(0, 1, 0, 0, 1, 32, 32'h80, 34);
      tbl[29] = mk(0, 1, 0, 0, 1, 33, 32'h84, 35);
      tbl[30] = mk(0, 1, 0, 0, 1, 34, 32'h88, 36);
      // ROM index wrap at 2^ADDR_W words
      tbl[31] = mk(0, 1, 1, 32'h7FC, 1, 35, 32'h8C, 511);
      tbl[32] = mk(0, 1, 0, 0, 0, 32'h13, 0, 0);
      tbl[33] = mk(0, 1, 0, 0, 1, 511, 32'h7FC, 1);
      tbl[34] = mk(0, 1, 0, 0, 1, 0, 32'h800, 2);

      repeat (2) @(posedge clka);
      #1;

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].rst, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
         chk_head($sformatf("row%0d", i), tbl[i].vld, tbl[i].inst, tbl[i].pc);
         chk($sformatf("row%0d_addra", i), 32'(addra), 32'(tbl[i].addr));
         tick();
      end

      // 32-bit PC wrap
      drive(0, 1, 1, 32'hFFFF_FFFC);
      chk("pcwrap_addra", 32'(addra), 32'd511);
      tick();
      drive(0, 1, 0, 0);
      chk("pcwrap_gap_valid", 32'(inst_valid_o), 32'd0);
      tick();
      drive(0, 1, 0, 0);
      chk_head("pcwrap_first", 1, 511, 32'hFFFF_FFFC);
      tick();
      drive(0, 1, 0, 0);
      chk_head("pcwrap_next", 1, 0, 32'h0);
      tick();

`ifdef IFU_ALIGN_CHK_EN
      drive(0, 1, 1, 32'h102);
      tick();
      drive(0, 1, 0, 0);
      chk_head("mis_entry", 1, 32'h13, 32'h102);
      chk("mis_flag", 32'(inst_misalign_o), 32'd1);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 0, 0);
         chk($sformatf("mis_halt%0d_valid", i), 32'(inst_valid_o), 32'd0);
         tick();
      end
      drive(0, 1, 1, 32'h200);
      tick();
      drive(0, 1, 0, 0);
      chk("resume_gap_valid", 32'(inst_valid_o), 32'd0);
      tick();
      drive(0, 1, 0, 0);
      chk_head("resume_first", 1, 128, 32'h200);
      chk("resume_flag", 32'(inst_misalign_o), 32'd0);
      tick();
      drive(0, 1, 0, 0);
      chk_head("resume_next", 1, 129, 32'h204);
      tick();
`else
      drive(0, 1, 1, 32'h102);
      chk("lowbits_addra", 32'(addra), 32'd64);
      tick();
      drive(0, 1, 0, 0);
      chk("lowbits_gap_valid", 32'(inst_valid_o), 32'd0);
      tick();
      drive(0, 1, 0, 0);
      chk_head("lowbits_first", 1, 64, 32'h100);
      tick();
      drive(0, 1, 0, 0);
      chk_head("lowbits_next", 1, 65, 32'h104);
      tick();
`endif

      // redirect asserted during reset must be ignored
      drive(1, 1, 1, 32'h300);
      chk("rstredir_addra", 32'(addra), 32'd0);
      tick();
      drive(0, 1, 0, 0);
      chk("rstredir_rel_valid", 32'(inst_valid_o), 32'd0);
      chk("rstredir_rel_addra", 32'(addra), 32'd0);
      tick();
      drive(0, 1, 0, 0);
      chk("rstredir_gap_valid", 32'(inst_valid_o), 32'd0);
      tick();
      drive(0, 1, 0, 0);
      chk_head("rstredir_first", 1, 0, 32'h0);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
